// File: rtl/tinyqv_muldiv_pkg.sv
// Shared definitions for the TinyQV serial multiply/divide unit:
// funct3 encodings, FSM states and small op-decoding helpers.
package tinyqv_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/tinyqv_muldiv_if.sv
// Core-side serial bus of the multiply/divide unit: the core (master) streams
// operand slices in, the unit (slave) streams the result slice out.
interface tinyqv_muldiv_if #(
  parameter int SLICE = 4,
  parameter int CW    = 3
);
  logic [CW-1:0]    counter;
  logic             start;
  logic [2:0]       op;
  logic [SLICE-1:0] a_in;
  logic [SLICE-1:0] b_in;
  logic             cancel;
  logic             busy;
  logic [SLICE-1:0] result;
  logic             result_valid;
  logic             done;

  modport master (
    output counter, start, op, a_in, b_in, cancel,
    input  busy, result, result_valid, done
  );

  modport slave (
    input  counter, start, op, a_in, b_in, cancel,
    output busy, result, result_valid, done
  );
endinterface

// File: rtl/tinyqv_serial_negate.sv
// SLICE-bit conditional two's-complement stage. The carry between slices is
// registered; 'first' selects carry_init instead of the stored carry.
module tinyqv_serial_negate #(
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             first,
  input  logic             negate,
  input  logic             carry_init,
  input  logic [SLICE-1:0] data_in,
  output logic [SLICE-1:0] data_out
);

  logic           carry_reg;
  logic           carry_in;
  logic [SLICE:0] sum;

  assign carry_in = first ? carry_init : carry_reg;
  assign sum      = {1'b0, ~data_in} + {{SLICE{1'b0}}, carry_in};
  assign data_out = negate ? sum[SLICE-1:0] : data_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_reg <= 1'b0;
    end else if (en) begin
      carry_reg <= sum[SLICE];
    end
  end

endmodule

// File: rtl/tinyqv_muldiv.sv
// Serial RV32M multiply/divide unit: operands arrive SLICE bits per clock,
// one shift-add / restoring-divide step per clock, result streamed out LSB first.
module tinyqv_muldiv
  import tinyqv_muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SLICE      = 4,
  parameter int NUM_SLICES = XLEN / SLICE,
  parameter int CW         = $clog2(NUM_SLICES)
) (
  input logic            clk,
  input logic            rst,
  tinyqv_muldiv_if.slave bus
);

  localparam int RW = (SLICE > 1) ? $clog2(SLICE) : 1;
  localparam logic [CW-1:0] LAST    = CW'(NUM_SLICES - 1);
  localparam logic [CW-1:0] PRELAST = CW'(NUM_SLICES - 2);
  localparam logic [RW-1:0] RND_LAST = RW'(SLICE - 1);

  state_t state_reg, state_next;
  logic   busy_reg, busy_next;
  logic   valid_reg, valid_next;
  logic   done_reg, done_next;

  logic [2:0]        op_reg;
  logic [XLEN-1:0]   a_reg;
  logic [XLEN-1:0]   b_reg;
  logic [2*XLEN-1:0] p_reg;
  logic              sign_a_reg;
  logic              sign_b_reg;
  logic              div_zero_reg;
  logic [RW-1:0]     rnd_reg;
  logic [XLEN-1:0]   out_reg;
  logic              out_neg_reg;
  logic              out_cinit_reg;

  logic round_end;
  logic accept;
  logic calc_last;

  assign round_end = (bus.counter == LAST);
  assign accept    = (state_reg == ST_IDLE) && bus.start && (bus.counter == '0);
  assign calc_last = (state_reg == ST_CALC) && round_end && (rnd_reg == RND_LAST);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept)    state_next = ST_LOAD;
      ST_LOAD: if (round_end) state_next = ST_CALC;
      ST_CALC: if (calc_last) state_next = ST_OUT;
      ST_OUT:  if (round_end) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
    if (bus.cancel && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
    end
  end

  // done is registered one clock early so it lands on the last OUT clock
  always_comb begin
    busy_next  = (state_next != ST_IDLE);
    valid_next = (state_next == ST_OUT);
    done_next  = (state_next == ST_OUT) && (bus.counter == PRELAST);
  end

  // ---------------- operand capture ----------------
  logic [XLEN-1:0] a_full, b_full;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            neg_a, neg_b;

  assign a_full = {bus.a_in, a_reg[XLEN-1:SLICE]};
  assign b_full = {bus.b_in, b_reg[XLEN-1:SLICE]};
  assign neg_a  = op_a_signed(op_reg) & a_full[XLEN-1];
  assign neg_b  = op_b_signed(op_reg) & b_full[XLEN-1];
  assign a_mag  = neg_a ? (~a_full + XLEN'(1)) : a_full;
  assign b_mag  = neg_b ? (~b_full + XLEN'(1)) : b_full;

  // ---------------- one iteration of shift-add / restoring divide ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] div_step;
  logic [2*XLEN-1:0] p_step;

  assign mul_sum  = {1'b0, p_reg[2*XLEN-1:XLEN]} + {1'b0, a_reg & {XLEN{p_reg[0]}}};
  assign mul_step = {mul_sum, p_reg[XLEN-1:1]};

  // p_reg holds {remainder, quotient}; the dividend enters through the quotient half
  assign div_shift = p_reg[2*XLEN-1:XLEN-1];
  assign div_diff  = {1'b0, div_shift} - {2'b00, b_reg};
  assign div_ok    = ~div_diff[XLEN+1];
  assign div_step  = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                      p_reg[XLEN-2:0], div_ok};

  assign p_step = op_is_div(op_reg) ? div_step : mul_step;

  // ---------------- result word selection ----------------
  logic [XLEN-1:0] word_next;
  logic            neg_next;
  logic            cinit_next;

  always_comb begin
    word_next  = p_step[XLEN-1:0];
    neg_next   = sign_a_reg ^ sign_b_reg;
    cinit_next = 1'b1;
    if (op_is_div(op_reg)) begin
      if (op_reg[1]) begin
        word_next = p_step[2*XLEN-1:XLEN];
        neg_next  = sign_a_reg;
      end else begin
        neg_next  = (sign_a_reg ^ sign_b_reg) & ~div_zero_reg;
      end
    end else if (op_reg != OP_MUL) begin
      // high half of a negated product only takes the +1 if the low half is all zero
      word_next  = p_step[2*XLEN-1:XLEN];
      cinit_next = (p_step[XLEN-1:0] == '0);
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      p_reg         <= '0;
      sign_a_reg    <= 1'b0;
      sign_b_reg    <= 1'b0;
      div_zero_reg  <= 1'b0;
      rnd_reg       <= '0;
      out_reg       <= '0;
      out_neg_reg   <= 1'b0;
      out_cinit_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op_reg <= bus.op;
            a_reg  <= {bus.a_in, a_reg[XLEN-1:SLICE]};
            b_reg  <= {bus.b_in, b_reg[XLEN-1:SLICE]};
          end
        end
        ST_LOAD: begin
          if (round_end) begin
            a_reg        <= a_mag;
            b_reg        <= b_mag;
            sign_a_reg   <= neg_a;
            sign_b_reg   <= neg_b;
            div_zero_reg <= (b_full == '0);
            p_reg        <= op_is_div(op_reg) ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            rnd_reg      <= '0;
          end else begin
            a_reg <= a_full;
            b_reg <= b_full;
          end
        end
        ST_CALC: begin
          p_reg <= p_step;
          if (round_end) begin
            rnd_reg <= rnd_reg + 1'b1;
          end
          if (calc_last) begin
            out_reg       <= word_next;
            out_neg_reg   <= neg_next;
            out_cinit_reg <= cinit_next;
          end
        end
        ST_OUT: begin
          out_reg <= out_reg >> SLICE;
        end
        default: ;
      endcase
    end
  end

  // ---------------- output stream ----------------
  logic [SLICE-1:0] neg_slice;

  tinyqv_serial_negate #(
    .SLICE (SLICE)
  ) u_negate (
    .clk        (clk),
    .rst        (rst),
    .en         (state_reg == ST_OUT),
    .first      (bus.counter == '0),
    .negate     (out_neg_reg),
    .carry_init (out_cinit_reg),
    .data_in    (out_reg[SLICE-1:0]),
    .data_out   (neg_slice)
  );

  assign bus.result       = valid_reg ? neg_slice : '0;
  assign bus.result_valid = valid_reg;
  assign bus.busy         = busy_reg;
  assign bus.done         = done_reg;

endmodule

// File: tb/tb_tinyqv_muldiv.sv
// Bench for tinyqv_muldiv: vector table through a result scoreboard, plus
// directed start-ignore, reset and cancel sequences.
module tb_tinyqv_muldiv;
  import tinyqv_muldiv_pkg::*;

  localparam int XLEN  = 32;
  localparam int SLICE = 4;
  localparam int NS    = XLEN / SLICE;
  localparam int CW    = $clog2(NS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tinyqv_muldiv_if #(.SLICE(SLICE), .CW(CW)) bus();

  tinyqv_muldiv #(
    .XLEN  (XLEN),
    .SLICE (SLICE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  // one clock: counter advances just after the edge, outputs sampled 1ns later
  task automatic tick();
    @(posedge clk);
    #1 bus.counter = bus.counter + 1'b1;
    #1;
  endtask

  task automatic add(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic load_op(input string name, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    while (bus.counter != '0) tick();
    for (int i = 0; i < NS; i++) begin
      bus.start = (i == 0);
      bus.op    = op;
      bus.a_in  = a[i*SLICE +: SLICE];
      bus.b_in  = b[i*SLICE +: SLICE];
      tick();
      if (i == 0) check({name, ".busy_rise"}, 32'(bus.busy), 32'd1);
    end
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
  endtask

  // poke_at >= 0 drives a stray start at that clock count (counter==0 when a multiple of NS)
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int poke_at);
    sb_t         e;
    logic [31:0] got;
    int          n, idx, done_at;
    load_op(name, op, a, b);
    e.exp = exp; e.name = name;
    sb_q.push_back(e);
    n = NS; idx = 0; done_at = -1; got = '0;
    while (done_at < 0 && n < 60) begin
      bus.start = (n == poke_at);
      bus.op    = (n == poke_at) ? OP_MUL : op;
      bus.a_in  = (n == poke_at) ? '1 : '0;
      bus.b_in  = (n == poke_at) ? '1 : '0;
      tick();
      n++;
      if (bus.result_valid && idx < NS) begin
        got[idx*SLICE +: SLICE] = bus.result;
        idx++;
      end
      if (bus.done) done_at = n;
    end
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    check({name, ".done_clk"}, 32'(done_at), 32'd47);
    check({name, ".slices"}, 32'(idx), 32'(NS));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.name, ".result"}, got, e.exp);
    end
    tick();
    check({name, ".busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, ".busy"},   32'(bus.busy), 32'd0);
    check({name, ".valid"},  32'(bus.result_valid), 32'd0);
    check({name, ".done"},   32'(bus.done), 32'd0);
    check({name, ".result"}, 32'(bus.result), 32'd0);
  endtask

  task automatic watch_quiet(input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 2 * NS * 3; i++) begin
      tick();
      if (bus.done || bus.busy) seen++;
    end
    check({name, ".quiet"}, 32'(seen), 32'd0);
  endtask

  initial begin
    int seen;
    bus.counter = '0;
    bus.start   = 1'b0;
    bus.op      = '0;
    bus.a_in    = '0;
    bus.b_in    = '0;
    bus.cancel  = 1'b0;
    rst         = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;

    add(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    add(OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB);
    add(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000);
    add(OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
    add(OP_MULH,   32'h80000000, 32'h00000002, 32'hFFFFFFFF);
    add(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    add(OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    add(OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780);
    add(OP_MUL,    32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA);
    add(OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
    add(OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
    add(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    add(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000);
    add(OP_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF);
    add(OP_DIV,    32'hFFFFFFEC, 32'h00000000, 32'hFFFFFFFF);
    add(OP_REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9);
    add(OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD);
    add(OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001);
    add(OP_DIVU,   32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF);
    add(OP_REMU,   32'hFFFFFFFF, 32'h00000010, 32'h0000000F);

    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d_op%0d", i, vecs[i].op), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].exp, -1);
    end

    // start away from counter==0 must not launch anything
    while (bus.counter != 3'd3) tick();
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a_in = 4'd5; bus.b_in = 4'd1;
    tick();
    bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.busy) seen++;
      tick();
    end
    check("late_start.busy", 32'(seen), 32'd0);

    // stray start at counter==0 during CALC
    do_op("calc_start", OP_DIVU, 32'd100, 32'd7, 32'd14, 3 * NS);

    // reset in the middle of CALC
    load_op("rst_calc", OP_MUL, 32'd3, 32'd5);
    repeat (12) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("rst_calc");
    watch_quiet("rst_calc");

    // cancel in the middle of OUT
    load_op("cancel_out", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (34) tick();
    check("cancel_out.valid_before", 32'(bus.result_valid), 32'd1);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check_idle_outputs("cancel_out");
    watch_quiet("cancel_out");

    do_op("after_abort_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, -1);
    do_op("after_abort_remu", OP_REMU, 32'd100, 32'd7, 32'd2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
